// File: rtl/i2c_master_core.sv
// rtl/i2c_master_core.sv - single-master I2C controller: START, addr+R/W, N data bytes, STOP
// Optional I2C_CLK_STRETCH_EN: freezes SCL high-phase timing while a target holds SCL low.
module i2c_master_core #(
  parameter int CLK_DIV = 250,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [6:0]       i_cmd_addr,
  input  logic             i_cmd_rw,
  input  logic [LEN_W-1:0] i_cmd_len,
  input  logic [7:0]       i_tx_data,
  output logic             o_tx_ack,
  output logic [7:0]       o_rx_data,
  output logic             o_rx_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_nack_err,
  input  logic             i_scl_in,
  input  logic             i_sda_in,
  output logic             o_scl_oe,
  output logic             o_sda_oe
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE, S_WR_ACK, S_READ, S_RD_ACK, S_STOP
  } state_t;

  state_t           r_state;
  logic [QW-1:0]    r_qcnt;
  logic [1:0]       r_q;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_rw;
  logic             r_sample;
  logic [LEN_W-1:0] r_len;

  logic w_qend;
  logic w_freeze;
  logic w_tick;
  logic w_more;

`ifdef I2C_CLK_STRETCH_EN
  logic w_bit_state;
  // Only bit phases stretch; START/STOP drive SCL themselves and must never stall.
  assign w_bit_state = !(r_state inside {S_IDLE, S_START, S_STOP});
  assign w_freeze    = w_bit_state && r_q[1] && !i_scl_in;
`else
  logic w_unused_scl;
  assign w_unused_scl = i_scl_in;
  assign w_freeze     = 1'b0;
`endif

  assign w_qend = (r_qcnt == QW'(CLK_DIV - 1));
  assign w_tick = w_qend && !w_freeze;
  assign w_more = (r_len > LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_qcnt      <= '0;
      r_q         <= 2'd0;
      r_bit       <= 3'd7;
      r_shift     <= 8'h00;
      r_rw        <= 1'b0;
      r_sample    <= 1'b1;
      r_len       <= '0;
      o_cmd_ready <= 1'b1;
      o_tx_ack    <= 1'b0;
      o_rx_data   <= 8'h00;
      o_rx_valid  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_nack_err  <= 1'b0;
      o_scl_oe    <= 1'b0;
      o_sda_oe    <= 1'b0;
    end else begin
      o_tx_ack   <= 1'b0;
      o_rx_valid <= 1'b0;
      o_done     <= 1'b0;
      if (r_state == S_IDLE) begin
        r_qcnt <= '0;
        r_q    <= 2'd0;
        if (o_cmd_ready && i_cmd_valid) begin
          o_cmd_ready <= 1'b0;
          o_busy      <= 1'b1;
          o_nack_err  <= 1'b0;
          r_shift     <= {i_cmd_addr, i_cmd_rw};
          r_rw        <= i_cmd_rw;
          r_len       <= i_cmd_len;
          r_bit       <= 3'd7;
          r_state     <= S_START;
        end else begin
          o_cmd_ready <= 1'b1;
          o_busy      <= 1'b0;
        end
      end else begin
        if (!w_freeze) r_qcnt <= w_qend ? '0 : r_qcnt + QW'(1);
        // The write byte is taken in the tx_ack cycle so the host may change it afterwards.
        if (r_state == S_WRITE && o_tx_ack) begin
          r_shift  <= i_tx_data;
          o_sda_oe <= ~i_tx_data[7];
        end
        if (w_tick) begin
          r_q <= r_q + 2'd1;
          case (r_state)
            S_START: begin
              case (r_q)
                2'd1: o_sda_oe <= 1'b1;
                2'd2: o_scl_oe <= 1'b1;
                2'd3: begin
                  r_state  <= S_ADDR;
                  o_sda_oe <= ~r_shift[7];
                end
                default: ;
              endcase
            end
            S_STOP: begin
              case (r_q)
                2'd0: o_scl_oe <= 1'b0;
                2'd1: o_sda_oe <= 1'b0;
                2'd2: begin
                  o_done  <= 1'b1;
                  r_state <= S_IDLE;
                end
                default: ;
              endcase
            end
            default: begin
              case (r_q)
                2'd1: o_scl_oe <= 1'b0;
                2'd2: begin
                  r_sample <= i_sda_in;
                  if (r_state == S_READ) r_shift <= {r_shift[6:0], i_sda_in};
                end
                2'd3: begin
                  o_scl_oe <= 1'b1;
                  case (r_state)
                    S_ADDR, S_WRITE: begin
                      if (r_bit == 3'd0) begin
                        o_sda_oe <= 1'b0;
                        r_state  <= (r_state == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
                      end else begin
                        r_bit    <= r_bit - 3'd1;
                        r_shift  <= {r_shift[6:0], 1'b0};
                        o_sda_oe <= ~r_shift[6];
                      end
                    end
                    S_ADDR_ACK: begin
                      r_bit <= 3'd7;
                      if (r_sample || r_len == '0) begin
                        if (r_sample) o_nack_err <= 1'b1;
                        o_sda_oe <= 1'b1;
                        r_state  <= S_STOP;
                      end else if (r_rw) begin
                        r_state <= S_READ;
                      end else begin
                        o_tx_ack <= 1'b1;
                        r_state  <= S_WRITE;
                      end
                    end
                    S_WR_ACK: begin
                      if (r_len != '0) r_len <= r_len - LEN_W'(1);
                      r_bit <= 3'd7;
                      if (r_sample || !w_more) begin
                        if (r_sample) o_nack_err <= 1'b1;
                        o_sda_oe <= 1'b1;
                        r_state  <= S_STOP;
                      end else begin
                        o_tx_ack <= 1'b1;
                        r_state  <= S_WRITE;
                      end
                    end
                    S_READ: begin
                      if (r_bit == 3'd0) begin
                        o_rx_data  <= r_shift;
                        o_rx_valid <= 1'b1;
                        o_sda_oe   <= w_more;
                        r_state    <= S_RD_ACK;
                      end else begin
                        r_bit <= r_bit - 3'd1;
                      end
                    end
                    S_RD_ACK: begin
                      if (r_len != '0) r_len <= r_len - LEN_W'(1);
                      r_bit <= 3'd7;
                      if (w_more) begin
                        o_sda_oe <= 1'b0;
                        r_state  <= S_READ;
                      end else begin
                        o_sda_oe <= 1'b1;
                        r_state  <= S_STOP;
                      end
                    end
                    default: ;
                  endcase
                end
                default: ;
              endcase
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_core.sv
// tb/tb_i2c_master_core.sv - scoreboard bench for i2c_master_core with a behavioural target at 0x55
module tb_i2c_master_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic [6:0] i_cmd_addr = 7'h00;
  logic       i_cmd_rw = 1'b0;
  logic [3:0] i_cmd_len = 4'd0;
  logic [7:0] i_tx_data = 8'h00;
  logic       o_cmd_ready, o_tx_ack, o_rx_valid, o_busy, o_done, o_nack_err;
  logic [7:0] o_rx_data;
  logic       o_scl_oe, o_sda_oe;
  logic       w_scl_in, w_sda_in;
  logic       tb_hold = 1'b0;
  logic       slv_oe = 1'b0;

  assign w_scl_in = ~o_scl_oe & ~tb_hold;
  assign w_sda_in = ~o_sda_oe & ~slv_oe;

  i2c_master_core #(.CLK_DIV(4), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_rw(i_cmd_rw), .i_cmd_len(i_cmd_len),
    .i_tx_data(i_tx_data), .o_tx_ack(o_tx_ack),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
    .o_busy(o_busy), .o_done(o_done), .o_nack_err(o_nack_err),
    .i_scl_in(w_scl_in), .i_sda_in(w_sda_in),
    .o_scl_oe(o_scl_oe), .o_sda_oe(o_sda_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [8:0] exp_frame_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] slv_rd [0:1];

  logic       p_scl = 1'b1, p_sda = 1'b1, scl_m, sda_m;
  logic       active = 1'b0, matched = 1'b0, m_rw = 1'b0, seen_rise = 1'b0;
  logic [8:0] frame = 9'h0;
  logic [7:0] rd_b;
  int         nbits = 0, byte_idx = 0, pulses = 0, tx_acks = 0, dones = 0, stops = 0;

  // Bus monitor and target model; SCL is observed from the master's drive.
  always @(negedge clk) begin
    scl_m = ~o_scl_oe;
    sda_m = w_sda_in;
    if (!rst_n) begin
      active = 1'b0; matched = 1'b0; seen_rise = 1'b0; slv_oe = 1'b0;
    end else begin
      if (o_tx_ack) tx_acks++;
      if (o_done) dones++;
      if (o_rx_valid) begin
        check("rx_q_avail", exp_rx_q.size() != 0, 1);
        if (exp_rx_q.size() != 0) check("rx_data", o_rx_data, exp_rx_q.pop_front());
      end
      if (p_scl && scl_m && p_sda && !sda_m) begin
        active = 1'b1; nbits = 0; byte_idx = 0; matched = 1'b0; seen_rise = 1'b0; slv_oe = 1'b0;
      end else if (p_scl && scl_m && !p_sda && sda_m) begin
        active = 1'b0; stops++; slv_oe = 1'b0;
      end else if (active && !p_scl && scl_m) begin
        frame = {frame[7:0], sda_m};
        nbits++;
        seen_rise = 1'b1;
        if (nbits == 9) begin
          check("frame_q_avail", exp_frame_q.size() != 0, 1);
          if (exp_frame_q.size() != 0) check("bus_frame", frame, exp_frame_q.pop_front());
          if (byte_idx > 0 && m_rw && sda_m) matched = 1'b0;
          nbits = 0;
          byte_idx++;
        end
      end else if (active && p_scl && !scl_m) begin
        if (seen_rise) pulses++;
        seen_rise = 1'b0;
        if (nbits == 8) begin
          if (byte_idx == 0) begin
            matched = (frame[7:1] == 7'h55);
            m_rw    = frame[0];
            slv_oe  = matched;
          end else begin
            slv_oe = matched && !m_rw;
          end
        end else if (matched && m_rw && byte_idx > 0 && byte_idx <= 2) begin
          rd_b   = slv_rd[byte_idx-1];
          slv_oe = ~rd_b[3'(7 - nbits)];
        end else begin
          slv_oe = 1'b0;
        end
      end
    end
    p_scl = scl_m;
    p_sda = sda_m;
  end

  always @(negedge clk) begin
    if (rst_n && o_tx_ack) begin
      @(posedge clk);
      #1;
      if (tx_q.size() != 0) i_tx_data = tx_q.pop_front();
    end
  end

  task automatic clear_counts();
    tx_acks = 0; dones = 0; pulses = 0; stops = 0;
  endtask

  task automatic issue(input logic [6:0] a, input logic rw, input logic [3:0] len);
    for (int i = 0; i < 200 && !o_cmd_ready; i++) @(negedge clk);
    check("cmd_ready_wait", o_cmd_ready, 1);
    i_cmd_valid = 1'b1; i_cmd_addr = a; i_cmd_rw = rw; i_cmd_len = len;
    @(negedge clk);
    i_cmd_valid = 1'b0; i_cmd_addr = ~a; i_cmd_rw = ~rw; i_cmd_len = ~len;
    check("busy_after_accept", o_busy, 1);
    check("ready_after_accept", o_cmd_ready, 0);
  endtask

  task automatic run_cmd(input logic [6:0] a, input logic rw, input logic [3:0] len, input bit dup);
    clear_counts();
    issue(a, rw, len);
    if (dup) begin
      repeat (10) @(negedge clk);
      i_cmd_valid = 1'b1; i_cmd_addr = 7'h2A; i_cmd_rw = 1'b1; i_cmd_len = 4'd5;
      @(negedge clk);
      i_cmd_valid = 1'b0;
    end
    for (int i = 0; i < 5000 && !o_done; i++) @(negedge clk);
    check("done_pulse", o_done, 1);
    @(negedge clk);
    check("busy_after_done", o_busy, 0);
    check("ready_after_done", o_cmd_ready, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic stretch_probe(output int dur);
    int  rel;
    logic prev;
    rel = 0; prev = 1'b0; dur = 0;
    for (int i = 0; i < 2000 && rel < 5; i++) begin
      @(negedge clk);
      if (prev && !o_scl_oe) rel++;
      prev = o_scl_oe;
    end
    tb_hold = 1'b1;
    for (int k = 1; k <= 200 && (dur == 0 || k <= 20); k++) begin
      @(negedge clk);
      if (k == 20) tb_hold = 1'b0;
      if (o_scl_oe && dur == 0) dur = k;
    end
    tb_hold = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   dur;
    int   rel;
    logic prev;
    slv_rd[0] = 8'h3C;
    slv_rd[1] = 8'hC3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", o_cmd_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_tx_ack", o_tx_ack, 0);
    check("rst_rx_valid", o_rx_valid, 0);
    check("rst_rx_data", o_rx_data, 0);
    check("rst_nack_err", o_nack_err, 0);
    check("rst_scl_oe", o_scl_oe, 0);
    check("rst_sda_oe", o_sda_oe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    i_tx_data = 8'hA5;
    exp_frame_q.push_back({8'hAA, 1'b0});
    exp_frame_q.push_back({8'hA5, 1'b0});
    run_cmd(7'h55, 1'b0, 4'd1, 1'b0);
    check("w1_tx_acks", tx_acks, 1);
    check("w1_dones", dones, 1);
    check("w1_nack_err", o_nack_err, 0);
    check("w1_scl_pulses", pulses, 18);
    check("w1_stops", stops, 1);
    check("w1_frames_left", exp_frame_q.size(), 0);

    exp_frame_q.push_back({8'h54, 1'b1});
    run_cmd(7'h2A, 1'b0, 4'd1, 1'b0);
    check("nk_nack_err", o_nack_err, 1);
    check("nk_tx_acks", tx_acks, 0);
    check("nk_dones", dones, 1);
    check("nk_stops", stops, 1);
    check("nk_frames_left", exp_frame_q.size(), 0);

    exp_frame_q.push_back({8'hAB, 1'b0});
    exp_frame_q.push_back({8'h3C, 1'b0});
    exp_frame_q.push_back({8'hC3, 1'b1});
    exp_rx_q.push_back(8'h3C);
    exp_rx_q.push_back(8'hC3);
    run_cmd(7'h55, 1'b1, 4'd2, 1'b0);
    check("rd_nack_err", o_nack_err, 0);
    check("rd_stops", stops, 1);
    check("rd_frames_left", exp_frame_q.size(), 0);
    check("rd_rx_left", exp_rx_q.size(), 0);

    i_tx_data = 8'h12;
    tx_q.push_back(8'h34);
    exp_frame_q.push_back({8'hAA, 1'b0});
    exp_frame_q.push_back({8'h12, 1'b0});
    exp_frame_q.push_back({8'h34, 1'b0});
    run_cmd(7'h55, 1'b0, 4'd2, 1'b0);
    check("w2_tx_acks", tx_acks, 2);
    check("w2_scl_pulses", pulses, 27);
    check("w2_frames_left", exp_frame_q.size(), 0);

    i_tx_data = 8'h11;
    exp_frame_q.push_back({8'hAA, 1'b0});
    exp_frame_q.push_back({8'h11, 1'b0});
    run_cmd(7'h55, 1'b0, 4'd1, 1'b1);
    check("dup_dones", dones, 1);
    check("dup_tx_acks", tx_acks, 1);
    check("dup_frames_left", exp_frame_q.size(), 0);

    i_tx_data = 8'h5A;
    exp_frame_q.push_back({8'hAA, 1'b0});
    exp_frame_q.push_back({8'h5A, 1'b0});
    fork
      run_cmd(7'h55, 1'b0, 4'd1, 1'b0);
      stretch_probe(dur);
    join
`ifdef I2C_CLK_STRETCH_EN
    check("stretch_high_cycles", dur, 28);
`else
    check("stretch_high_cycles", dur, 8);
`endif
    check("stretch_frames_left", exp_frame_q.size(), 0);
    check("stretch_nack_err", o_nack_err, 0);

    clear_counts();
    i_tx_data = 8'hA5;
    issue(7'h55, 1'b0, 4'd1);
    rel = 0; prev = 1'b0;
    for (int i = 0; i < 500 && rel < 1; i++) begin
      @(negedge clk);
      if (prev && !o_scl_oe) rel++;
      prev = o_scl_oe;
    end
    for (int i = 0; i < 500 && !o_scl_oe; i++) @(negedge clk);
    check("pre_rst_scl_oe", o_scl_oe, 1);
    check("pre_rst_sda_oe", o_sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_scl_oe", o_scl_oe, 0);
    check("mid_rst_sda_oe", o_sda_oe, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_cmd_ready", o_cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_dones", dones, 0);

    exp_frame_q.push_back({8'hAA, 1'b0});
    run_cmd(7'h55, 1'b0, 4'd0, 1'b0);
    check("probe_tx_acks", tx_acks, 0);
    check("probe_scl_pulses", pulses, 9);
    check("probe_nack_err", o_nack_err, 0);
    check("probe_frames_left", exp_frame_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
